// File: rtl/sync_fifo_swmr.sv
// Purpose : same-clock FIFO taking one WR_WIDTH word per write and returning it as
//           RATIO RD_WIDTH slices, least-significant slice first.
// Latency : rd_data/rd_valid appear one cycle after an accepted rd_en; no write-to-read bypass.
// Backpressure: full blocks writes until the head entry's last slice has been read;
//           rejected requests raise a one-cycle overflow/underflow pulse.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   wr_en, wr_data, full    wide write side; overflow pulses after a write while full
//   rd_en, rd_data, rd_valid narrow read side; underflow pulses after a read while empty
//   empty, rd_count         narrow-word occupancy derived from the registered pointers
module sync_fifo_swmr #(
    parameter int WR_WIDTH      = 32,
    parameter int RD_WIDTH      = 16,
    parameter int WR_DEPTH      = 8,
    parameter int RATIO         = WR_WIDTH / RD_WIDTH,
    parameter int WR_ADDR_WIDTH = $clog2(WR_DEPTH),
    parameter int RD_CNT_WIDTH  = $clog2(WR_DEPTH * RATIO) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WR_WIDTH-1:0]     wr_data,
    output logic                    full,
    output logic                    overflow,
    input  logic                    rd_en,
    output logic [RD_WIDTH-1:0]     rd_data,
    output logic                    rd_valid,
    output logic                    empty,
    output logic                    underflow,
    output logic [RD_CNT_WIDTH-1:0] rd_count
);

    localparam int RATIO_LOG2 = $clog2(RATIO);
    localparam int SLICE_W    = (RATIO > 1) ? RATIO_LOG2 : 1;
    localparam logic [RD_CNT_WIDTH-1:0] FULL_THR = RD_CNT_WIDTH'((WR_DEPTH - 1) * RATIO);

    // Each entry viewed as RATIO slices; slice 0 holds the LSBs.
    typedef logic [RATIO-1:0][RD_WIDTH-1:0] word_t;

    word_t                    mem [WR_DEPTH];
    logic [WR_ADDR_WIDTH:0]   wr_ptr;
    logic [RD_CNT_WIDTH-1:0]  rd_ptr;
    logic [RD_CNT_WIDTH-1:0]  wr_ptr_narrow;
    logic [WR_ADDR_WIDTH-1:0] wr_addr;
    logic [WR_ADDR_WIDTH-1:0] rd_addr;
    logic [SLICE_W-1:0]       slice_sel;
    logic                     wr_accept;
    logic                     rd_accept;

    // Wide pointer scaled to narrow units; the subtraction wraps naturally,
    // so the extra MSB on both pointers separates full from empty.
    assign wr_ptr_narrow = RD_CNT_WIDTH'(wr_ptr) << RATIO_LOG2;
    assign rd_count      = wr_ptr_narrow - rd_ptr;
    assign empty         = (rd_count == '0);
    // A partially read head entry still occupies its slot.
    assign full          = (rd_count > FULL_THR);

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    assign wr_addr   = wr_ptr[WR_ADDR_WIDTH-1:0];
    // Upper rd_ptr bits (below the wrap bit) select the entry, low bits the slice.
    assign rd_addr   = rd_ptr[RD_CNT_WIDTH-2 -: WR_ADDR_WIDTH];
    assign slice_sel = (RATIO > 1) ? rd_ptr[SLICE_W-1:0] : '0;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            rd_valid  <= rd_accept;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_data <= mem[rd_addr][slice_sel];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_swmr.sv
// Purpose : self-checking bench for sync_fifo_swmr with default parameters (32 -> 2 x 16, depth 8).
// Latency : expects read data one cycle after each accepted rd_en.
// Backpressure: a reference model predicts full/empty/overflow/underflow every cycle.
module tb_sync_fifo_swmr;

    localparam int WR_WIDTH = 32;
    localparam int RD_WIDTH = 16;
    localparam int WR_DEPTH = 8;
    localparam int RATIO    = WR_WIDTH / RD_WIDTH;
    localparam int RD_CNT_WIDTH = $clog2(WR_DEPTH * RATIO) + 1;
    localparam int FULL_THR = (WR_DEPTH - 1) * RATIO;

    logic                    clk;
    logic                    rst_n;
    logic                    wr_en;
    logic [WR_WIDTH-1:0]     wr_data;
    logic                    full;
    logic                    overflow;
    logic                    rd_en;
    logic [RD_WIDTH-1:0]     rd_data;
    logic                    rd_valid;
    logic                    empty;
    logic                    underflow;
    logic [RD_CNT_WIDTH-1:0] rd_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: stored wide words, read slice of the head, narrow count.
    logic [WR_WIDTH-1:0] model_q [$];
    logic [RD_WIDTH-1:0] sb [$];
    int                  m_slice = 0;
    int                  m_cnt = 0;
    logic [RD_WIDTH-1:0] last_rd = '0;

    sync_fifo_swmr #(
        .WR_WIDTH (WR_WIDTH),
        .RD_WIDTH (RD_WIDTH),
        .WR_DEPTH (WR_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .overflow  (overflow),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .underflow (underflow),
        .rd_count  (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every rd_valid must match the oldest expected slice.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("rd_data", 32'(rd_data), 32'(sb.pop_front()));
            end
        end
    end

    // One clock of stimulus; acceptance is decided on the model's pre-edge state.
    task automatic cycle(input bit we, input logic [WR_WIDTH-1:0] wd, input bit re);
        bit                  wacc;
        bit                  racc;
        logic [WR_WIDTH-1:0] head;
        logic [RD_WIDTH-1:0] exp_d;
        wacc = we && !(m_cnt > FULL_THR);
        racc = re && (m_cnt != 0);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        if (racc) begin
            head  = model_q[0];
            exp_d = RD_WIDTH'(head >> (m_slice * RD_WIDTH));
            sb.push_back(exp_d);
            last_rd = exp_d;
            m_slice++;
            if (m_slice == RATIO) begin
                m_slice = 0;
                void'(model_q.pop_front());
            end
        end
        if (wacc) model_q.push_back(wd);
        m_cnt = m_cnt + (wacc ? RATIO : 0) - (racc ? 1 : 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("overflow",  32'(overflow),  32'(we && !wacc));
        chk("underflow", 32'(underflow), 32'(re && !racc));
        chk("rd_valid",  32'(rd_valid),  32'(racc));
        chk("rd_count",  32'(rd_count),  32'(m_cnt));
        chk("empty",     32'(empty),     32'(m_cnt == 0));
        chk("full",      32'(full),      32'(m_cnt > FULL_THR));
        if (!racc) chk("rd_hold", 32'(rd_data), 32'(last_rd));
    endtask

    task automatic model_clear();
        model_q.delete();
        sb.delete();
        m_slice = 0;
        m_cnt   = 0;
        last_rd = '0;
    endtask

    initial begin
        int w;
        int r;
        bit we;
        bit re;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        #12;
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_count",    32'(rd_count), 32'd0);
        chk("rst_valid",    32'(rd_valid), 32'd0);
        chk("rst_data",     32'(rd_data),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle, then a read while empty.
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // One wide word, two narrow reads: AAAA then BBBB.
        cycle(1'b1, 32'hBBBB_AAAA, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Fill to capacity, then a rejected write.
        for (int i = 0; i < WR_DEPTH; i++) begin
            cycle(1'b1, {16'(i + 1), 16'(i)}, 1'b0);
        end
        chk("fill_count", 32'(rd_count), 32'd16);
        cycle(1'b1, 32'hDEAD_DEAD, 1'b0);
        // First slice read: head slot still held, so still full.
        cycle(1'b0, '0, 1'b1);
        chk("half_read_full", 32'(full), 32'd1);
        // Same-edge write and read while full: write rejected, read frees the slot.
        cycle(1'b1, 32'hCAFE_CAFE, 1'b1);
        chk("same_edge_full", 32'(full), 32'd0);
        while (m_cnt != 0) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        // Randomised streaming within the flags.
        w = 0;
        r = 0;
        for (int n = 0; n < 3000 && (w < 40 || r < 80); n++) begin
            we = (w < 40) && !(m_cnt > FULL_THR) && ($urandom_range(0, 3) != 0);
            re = (r < 80) && (m_cnt != 0) && ($urandom_range(0, 3) != 0);
            cycle(we, $urandom, re);
            w += int'(we);
            r += int'(re);
        end
        chk("stream_writes", 32'(w), 32'd40);
        chk("stream_reads",  32'(r), 32'd80);

        // Reset mid-stream with five slices stored and a read just returned.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h1111_0000 + 32'(i), 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("pre_rst_count", 32'(rd_count), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty),    32'd1);
        chk("arst_count", 32'(rd_count), 32'd0);
        chk("arst_valid", 32'(rd_valid), 32'd0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
